// File: rtl/cu_param.sv
// cu_param: multi-cycle control unit for the 8-bit Harvard CPU with parametrised data width and GPR count.
// Define CU_ILLEGAL_TRAP_EN to halt on undefined opcodes instead of executing them as NOP.
module cu_param #(
    parameter int DATA_W  = 8,
    parameter int NUM_GPR = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    output logic [7:0]        addr_program,
    input  logic [7:0]        data_program,
    output logic [7:0]        mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              mem_we,
    output logic              mem_re,
    input  logic              mem_ready,
    output logic [7:0]        alu_op,
    output logic [DATA_W-1:0] alu_a,
    output logic [DATA_W-1:0] alu_b,
    input  logic [DATA_W-1:0] alu_result,
    output logic              halted
);
    localparam int IW = $clog2(NUM_GPR);
`ifdef CU_ILLEGAL_TRAP_EN
    localparam bit TRAP = 1'b1;
`else
    localparam bit TRAP = 1'b0;
`endif

    typedef enum logic [2:0] {FETCH, DECODE, OP1, OP2, ALU, MEM, RETIRE, HALT} state_t;

    state_t            state, state_n;
    logic [7:0]        pc, cir, op1;
    logic [IW-1:0]     op2;
    logic [DATA_W-1:0] gpr [NUM_GPR];
    logic [DATA_W-1:0] jb_shift;
    logic              known, jump;

    assign addr_program = pc;
    assign halted       = (state == HALT);
    assign known        = cir inside {8'h00, 8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06,
                                      8'h07, 8'h08, 8'h09, 8'h12, 8'hFF};
    // Bit positions beyond the register width shift in zeros and so read as 0.
    assign jb_shift     = gpr[op1[IW-1:0]] >> op1[6:4];
    assign jump         = (cir == 8'h08) ? jb_shift[0] : !jb_shift[0];

    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) state <= FETCH;
        else        state <= state_n;

    always_comb begin
        state_n = state;
        case (state)
            FETCH:   state_n = DECODE;
            DECODE:  state_n = (cir == 8'h00 || cir == 8'h12) ? RETIRE :
                               (cir == 8'hFF) ? HALT : known ? OP1 : TRAP ? HALT : RETIRE;
            OP1:     state_n = (cir == 8'h07) ? FETCH :
                               (cir == 8'h01 || cir == 8'h02) ? ALU :
                               (cir == 8'h03) ? RETIRE : OP2;
            OP2:     state_n = (cir == 8'h04 || cir == 8'h05) ? MEM :
                               ((cir == 8'h08 || cir == 8'h09) && jump) ? FETCH : RETIRE;
            ALU:     state_n = RETIRE;
            MEM:     state_n = mem_ready ? RETIRE : MEM;
            RETIRE:  state_n = FETCH;
            default: state_n = HALT;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc        <= '0;
            cir       <= '0;
            op1       <= '0;
            op2       <= '0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            mem_we    <= 1'b0;
            mem_re    <= 1'b0;
            alu_op    <= '0;
            alu_a     <= '0;
            alu_b     <= '0;
            for (int i = 0; i < NUM_GPR; i++) gpr[i] <= '0;
        end else begin
            case (state)
                FETCH: cir <= data_program;
                DECODE: begin
                    if (cir == 8'h12) gpr[0] <= '0;
                    if (state_n == OP1) pc <= pc + 8'd1;
                end
                OP1: begin
                    op1 <= data_program;
                    case (cir)
                        8'h07: pc <= data_program;
                        8'h01, 8'h02: begin
                            alu_op <= cir;
                            alu_a  <= gpr[0];
                            alu_b  <= gpr[data_program[IW-1:0]];
                        end
                        8'h03: gpr[data_program[IW-1:0]] <= gpr[data_program[4+:IW]];
                        default: pc <= pc + 8'd1;
                    endcase
                end
                OP2: begin
                    op2 <= data_program[IW-1:0];
                    case (cir)
                        8'h06: gpr[data_program[IW-1:0]] <= DATA_W'(op1);
                        8'h04: begin
                            mem_addr  <= data_program;
                            mem_wdata <= gpr[op1[IW-1:0]];
                            mem_we    <= 1'b1;
                        end
                        8'h05: begin
                            mem_addr <= op1;
                            mem_re   <= 1'b1;
                        end
                        default: if (jump) pc <= data_program;
                    endcase
                end
                ALU: begin
                    gpr[0] <= alu_result;
                    alu_op <= '0;
                end
                MEM: if (mem_ready) begin
                    if (mem_re) gpr[op2] <= mem_rdata;
                    mem_we <= 1'b0;
                    mem_re <= 1'b0;
                end
                RETIRE: pc <= pc + 8'd1;
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_cu_param.sv
// tb_cu_param: directed programs checked against an instruction-level model of cu_param.
module tb_cu_param;
    logic       clk = 1'b0;
    logic       rst_n = 1'b1;
    logic [7:0] addr_program, data_program, mem_addr, alu_op;
    logic [7:0] mem_wdata, alu_a, alu_b, alu_result;
    logic [7:0] mem_rdata = 8'h00;
    logic       mem_we, mem_re, halted;
    logic       mem_ready = 1'b0;

    logic [7:0] prog [256];
    logic [7:0] dmem [256];
    logic [7:0] m_dmem [256];
    logic [7:0] m_gpr [8];
    logic [7:0] m_pc;
    logic       m_halt;

    int checks = 0, errors = 0;
    int wait_cycles = 0, busy_cnt = 0, cyc_total = 0, we_cnt = 0;
    logic       prev_we = 1'b0;
    logic [7:0] p_addr, p_wdata;
    logic [7:0] jb_val [4] = '{8'h80, 8'h7F, 8'h80, 8'h7F};
    logic [7:0] jb_op  [4] = '{8'h08, 8'h08, 8'h09, 8'h09};
    logic [7:0] jb_pc  [4] = '{8'h20, 8'h06, 8'h06, 8'h20};
    int         jb_cyc [4] = '{9, 10, 10, 9};

    always #5 clk = ~clk;

    assign data_program = prog[addr_program];
    assign alu_result   = (alu_op == 8'h01) ? alu_a + alu_b : (alu_op == 8'h02) ? alu_a - alu_b : 8'h00;

    cu_param dut (
        .clk(clk), .rst_n(rst_n),
        .addr_program(addr_program), .data_program(data_program),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
        .mem_we(mem_we), .mem_re(mem_re), .mem_ready(mem_ready),
        .alu_op(alu_op), .alu_a(alu_a), .alu_b(alu_b), .alu_result(alu_result),
        .halted(halted)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // One clock: advance to the falling edge, then act as the data memory for the next rising edge.
    task automatic tick();
        @(negedge clk);
        if (mem_we && prev_we) begin
            checks++;
            if (mem_addr !== p_addr || mem_wdata !== p_wdata) begin
                errors++;
                $display("FAIL mem_stable: got %h/%h expected %h/%h", mem_addr, mem_wdata, p_addr, p_wdata);
            end
        end
        prev_we = mem_we;
        p_addr  = mem_addr;
        p_wdata = mem_wdata;
        if (mem_we) we_cnt++;
        if (mem_we || mem_re) begin
            mem_ready = (busy_cnt >= wait_cycles);
            mem_rdata = dmem[mem_addr];
            if (mem_ready && mem_we) dmem[mem_addr] = mem_wdata;
            busy_cnt++;
        end else begin
            mem_ready = 1'b0;
            busy_cnt  = 0;
        end
        cyc_total++;
    endtask

    task automatic clear();
        for (int j = 0; j < 256; j++) prog[j] = 8'hFF;
    endtask

    task automatic put(input logic [7:0] at, input logic [7:0] b[$]);
        foreach (b[i]) prog[at + 8'(i)] = b[i];
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        #1;
        chk("rst_pc", addr_program, 0);
        chk("rst_we_re", {mem_we, mem_re}, 0);
        chk("rst_halted", halted, 0);
        chk("rst_alu", {alu_op, alu_a, alu_b}, 0);
        tick();
        tick();
        rst_n = 1'b1;
        m_pc = 8'h00;
        m_halt = 1'b0;
        foreach (m_gpr[j]) m_gpr[j] = 8'h00;
        for (int j = 0; j < 256; j++) m_dmem[j] = dmem[j];
        cyc_total = 0;
        we_cnt = 0;
    endtask

    task automatic model_step(output int cyc);
        logic [7:0] op, o1, o2, a1, a2, a3;
        logic       bt;
        a1 = m_pc + 8'd1;
        a2 = m_pc + 8'd2;
        a3 = m_pc + 8'd3;
        op = prog[m_pc];
        o1 = prog[a1];
        o2 = prog[a2];
        cyc = 3;
        if (op == 8'h00) m_pc = a1;
        else if (op == 8'h12) begin m_gpr[0] = 8'h00; m_pc = a1; end
        else if (op == 8'hFF) begin m_halt = 1'b1; cyc = 2; end
        else if (op == 8'h01) begin m_gpr[0] = m_gpr[0] + m_gpr[o1[2:0]]; m_pc = a2; cyc = 5; end
        else if (op == 8'h02) begin m_gpr[0] = m_gpr[0] - m_gpr[o1[2:0]]; m_pc = a2; cyc = 5; end
        else if (op == 8'h03) begin m_gpr[o1[2:0]] = m_gpr[o1[6:4]]; m_pc = a2; cyc = 4; end
        else if (op == 8'h04) begin m_dmem[o2] = m_gpr[o1[2:0]]; m_pc = a3; cyc = 6 + wait_cycles; end
        else if (op == 8'h05) begin m_gpr[o2[2:0]] = m_dmem[o1]; m_pc = a3; cyc = 6 + wait_cycles; end
        else if (op == 8'h06) begin m_gpr[o2[2:0]] = o1; m_pc = a3; cyc = 5; end
        else if (op == 8'h07) m_pc = o1;
        else if (op == 8'h08 || op == 8'h09) begin
            bt = m_gpr[o1[2:0]][o1[6:4]];
            if (bt == (op == 8'h08)) begin m_pc = o2; cyc = 4; end
            else begin m_pc = a3; cyc = 5; end
        end else begin
`ifdef CU_ILLEGAL_TRAP_EN
            m_halt = 1'b1;
            cyc = 2;
`else
            m_pc = a1;
`endif
        end
    endtask

    task automatic run(input int n);
        int cyc, mism;
        for (int i = 0; i < n; i++) begin
            if (m_halt) break;
            model_step(cyc);
            repeat (cyc) tick();
            chk("pc", addr_program, m_pc);
            chk("halted", halted, m_halt);
        end
        mism = 0;
        for (int j = 0; j < 256; j++) if (dmem[j] !== m_dmem[j]) mism++;
        chk("dmem", mism, 0);
    endtask

    initial begin
        for (int j = 0; j < 256; j++) dmem[j] = 8'h00;
        tick();
        // Immediate loads and ADD, then dump registers to memory.
        clear();
        put(8'h00, '{8'h06, 8'h5A, 8'h01, 8'h06, 8'h03, 8'h02, 8'h01, 8'h02,
                     8'h04, 8'h01, 8'h10, 8'h04, 8'h02, 8'h11, 8'h04, 8'h00, 8'h12, 8'hFF});
        wait_cycles = 0;
        do_reset();
        run(3);
        chk("prog1_pc", addr_program, 8'h08);
        chk("prog1_cycles", cyc_total, 15);
        run(20);
        chk("gpr1", dmem[8'h10], 8'h5A);
        chk("gpr2", dmem[8'h11], 8'h03);
        chk("gpr0", dmem[8'h12], 8'h03);
        // Store with three wait cycles.
        clear();
        put(8'h00, '{8'h06, 8'hA5, 8'h01, 8'h04, 8'h01, 8'h40, 8'hFF});
        wait_cycles = 3;
        do_reset();
        run(5);
        chk("we_cycles", we_cnt, 4);
        chk("store", dmem[8'h40], 8'hA5);
        chk("store_halt_pc", addr_program, 8'h06);
        // SUB, register moves, CLR and a load.
        clear();
        put(8'h00, '{8'h06, 8'h10, 8'h00, 8'h06, 8'h03, 8'h01, 8'h02, 8'h01, 8'h03, 8'h02, 8'h03, 8'h22,
                     8'h04, 8'h02, 8'h20, 8'h12, 8'h04, 8'h00, 8'h21, 8'h05, 8'h30, 8'h03,
                     8'h04, 8'h03, 8'h31, 8'hFF});
        dmem[8'h21] = 8'h77;
        dmem[8'h30] = 8'h3C;
        wait_cycles = 1;
        do_reset();
        run(30);
        chk("sub_mov", dmem[8'h20], 8'h0D);
        chk("clr", dmem[8'h21], 8'h00);
        chk("load", dmem[8'h31], 8'h3C);
        // JB / JNB taken and not taken on gpr1 bit 7.
        for (int k = 0; k < 4; k++) begin
            clear();
            put(8'h00, '{8'h06, jb_val[k], 8'h01, jb_op[k], 8'h71, 8'h20});
            do_reset();
            run(2);
            chk("jb_cycles", cyc_total, jb_cyc[k]);
            run(4);
            chk("jb_pc", addr_program, jb_pc[k]);
        end
        // JMP at 0xFE with its operand at 0xFF, then NOP at 0xFF.
        clear();
        put(8'h00, '{8'h07, 8'hFE});
        put(8'hFE, '{8'h07, 8'h00});
        do_reset();
        run(2);
        chk("wrap_jmp", addr_program, 8'h00);
        clear();
        put(8'h00, '{8'h07, 8'hFF});
        put(8'hFF, '{8'h00});
        do_reset();
        run(2);
        chk("wrap_nop", addr_program, 8'h00);
        chk("wrap_cycles", cyc_total, 6);
        // Reset while a read is pending; registers must come back cleared.
        clear();
        put(8'h00, '{8'h06, 8'h33, 8'h01, 8'h05, 8'h40, 8'h02});
        wait_cycles = 50;
        do_reset();
        run(1);
        repeat (4) tick();
        chk("re_pending", mem_re, 1);
        tick();
        clear();
        put(8'h00, '{8'h04, 8'h01, 8'h50, 8'h04, 8'h02, 8'h51, 8'hFF});
        dmem[8'h50] = 8'hEE;
        dmem[8'h51] = 8'hEE;
        wait_cycles = 0;
        do_reset();
        run(5);
        chk("rst_gpr1", dmem[8'h50], 8'h00);
        chk("rst_gpr2", dmem[8'h51], 8'h00);
        // Undefined opcode.
        clear();
        put(8'h00, '{8'h55});
        do_reset();
        run(3);
`ifdef CU_ILLEGAL_TRAP_EN
        chk("illegal_pc", addr_program, 8'h00);
        chk("illegal_cycles", cyc_total, 2);
`else
        chk("illegal_pc", addr_program, 8'h01);
        chk("illegal_cycles", cyc_total, 5);
`endif
        chk("illegal_halted", halted, 1);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
